// File: rtl/idft_wb_stream_feeder.sv
// Wishbone B3 slave buffering IDFT input samples and results, framing the input stream for the core.
// Optional interrupt output enabled by defining IDFT_FEEDER_IRQ_EN.
`default_nettype none

module idft_wb_stream_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [DATA_WIDTH-1:0] core_dat_o,
  output logic                  core_vld_o,
  output logic                  core_last_o,
  input  logic                  core_rdy_i,
  input  logic [DATA_WIDTH-1:0] res_dat_i,
  input  logic                  res_vld_i,
  output logic                  res_rdy_o
`ifdef IDFT_FEEDER_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_CNT  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DIN    = 2'd2;
  localparam logic [1:0] ADR_DOUT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] in_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];

  logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [CW-1:0] in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
  logic [CW-1:0] beat_cnt, res_cnt;

  logic       req, bad, ok;
  logic [1:0] reg_sel;
  logic       push_in, pop_in, push_out, pop_out;
  logic       flush, start_go, can_start, in_enough;
  logic       in_full, in_empty, out_empty, busy, done;
  logic       enter_done;
  logic [31:0]           status_word;
  logic [DATA_WIDTH-1:0] rd_data;

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  assign reg_sel   = wb_adr_i[3:2];
  assign req       = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);

  assign in_full   = (in_cnt == DEPTH_CNT);
  assign in_empty  = (in_cnt == '0);
  assign out_empty = (out_cnt == '0);
  assign in_enough = (in_cnt >= FRAME_CNT);
  assign busy      = (state == S_STREAM) || (state == S_WAIT);
  assign done      = (state == S_DONE);
  assign can_start = (state == S_IDLE) || (state == S_DONE);

  // Stream side is derived from registered state so it falls the cycle a flush lands.
  assign core_vld_o  = (state == S_STREAM) && !in_empty;
  assign core_dat_o  = core_vld_o ? in_mem[in_rd_ptr] : '0;
  assign core_last_o = core_vld_o && (beat_cnt == FRAME_LAST);

  assign pop_in     = core_vld_o & core_rdy_i;
  assign push_out   = res_vld_i & res_rdy_o;
  assign enter_done = (state == S_WAIT) && push_out && (res_cnt == FRAME_LAST) && !flush;

  assign status_word = {12'd0, out_empty, in_full, done, busy, 8'(out_cnt), 8'(in_cnt)};

  always_comb begin
    bad = 1'b0;
    case (reg_sel)
      ADR_CTRL:   bad = !wb_we_i || (wb_dat_i[0] && can_start && !in_enough);
      ADR_STATUS: bad = wb_we_i;
      ADR_DIN:    bad = !wb_we_i || in_full;
      ADR_DOUT:   bad = wb_we_i || out_empty;
      default:    bad = 1'b1;
    endcase
    if (wb_sel_i != 4'hF) begin
      bad = 1'b1;
    end
  end

  assign ok       = req & ~bad;
  assign push_in  = ok & wb_we_i & (reg_sel == ADR_DIN);
  assign pop_out  = ok & ~wb_we_i & (reg_sel == ADR_DOUT);
  assign flush    = ok & wb_we_i & (reg_sel == ADR_CTRL) & wb_dat_i[1];
  assign start_go = ok & wb_we_i & (reg_sel == ADR_CTRL) & wb_dat_i[0] & can_start & ~flush;

  always_comb begin
    rd_data = '0;
    if (ok && !wb_we_i) begin
      case (reg_sel)
        ADR_STATUS: rd_data = DATA_WIDTH'(status_word);
        ADR_DOUT:   rd_data = out_mem[out_rd_ptr];
        default:    rd_data = '0;
      endcase
    end
  end

  always_comb begin
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    if (flush) begin
      in_cnt_nxt  = '0;
      out_cnt_nxt = '0;
    end else begin
      if (push_in && !pop_in) begin
        in_cnt_nxt = in_cnt + 1'b1;
      end else if (!push_in && pop_in) begin
        in_cnt_nxt = in_cnt - 1'b1;
      end
      if (push_out && !pop_out) begin
        out_cnt_nxt = out_cnt + 1'b1;
      end else if (!push_out && pop_out) begin
        out_cnt_nxt = out_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_in) begin
      in_mem[in_wr_ptr] <= wb_dat_i;
    end
    if (push_out) begin
      out_mem[out_wr_ptr] <= res_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      res_rdy_o  <= 1'b0;
    end else begin
      in_cnt    <= in_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      // Registered so it is low during reset and exact against the next fill level.
      res_rdy_o <= (out_cnt_nxt != DEPTH_CNT);
      if (flush) begin
        in_wr_ptr  <= '0;
        in_rd_ptr  <= '0;
        out_wr_ptr <= '0;
        out_rd_ptr <= '0;
      end else begin
        if (push_in)  in_wr_ptr  <= in_wr_ptr + 1'b1;
        if (pop_in)   in_rd_ptr  <= in_rd_ptr + 1'b1;
        if (push_out) out_wr_ptr <= out_wr_ptr + 1'b1;
        if (pop_out)  out_rd_ptr <= out_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & ~bad;
      wb_err_o <= req & bad;
      wb_dat_o <= rd_data;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      res_cnt  <= '0;
    end else if (flush) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      res_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_go) begin
            state    <= S_STREAM;
            beat_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (pop_in) begin
            if (beat_cnt == FRAME_LAST) begin
              state   <= S_WAIT;
              res_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (push_out) begin
            if (res_cnt == FRAME_LAST) begin
              state <= S_DONE;
            end else begin
              res_cnt <= res_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start_go) begin
            state    <= S_STREAM;
            beat_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IDFT_FEEDER_IRQ_EN
  logic irq_clr;
  assign irq_clr = ok & wb_we_i & (reg_sel == ADR_CTRL) & wb_dat_i[2];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_o <= 1'b0;
    end else if (enter_done) begin
      irq_o <= 1'b1;
    end else if (irq_clr) begin
      irq_o <= 1'b0;
    end
  end
`else
  logic unused_done;
  assign unused_done = enter_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idft_wb_stream_feeder.sv
// Scoreboard bench for idft_wb_stream_feeder: WB host, stream sink and result loopback in one thread.
`default_nettype none

module tb_idft_wb_stream_feeder;

  localparam int FL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_rdat;
  logic        wb_ack, wb_err;
  logic [31:0] core_dat;
  logic        core_vld, core_last;
  logic        core_rdy = 1'b0;
  logic [31:0] res_dat = '0;
  logic        res_vld = 1'b0;
  logic        res_rdy;
`ifdef IDFT_FEEDER_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic [32:0] exp_in[$];
  logic [31:0] res_q[$];
  logic [31:0] exp_out[$];

  always #5 clk = ~clk;

  idft_wb_stream_feeder dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat),
    .wb_sel_i   (wb_sel),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_dat_o   (wb_rdat),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .core_dat_o (core_dat),
    .core_vld_o (core_vld),
    .core_last_o(core_last),
    .core_rdy_i (core_rdy),
    .res_dat_i  (res_dat),
    .res_vld_i  (res_vld),
    .res_rdy_o  (res_rdy)
`ifdef IDFT_FEEDER_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int in_c, input int out_c, input bit busy, input bit done);
    return {12'd0, (out_c == 0), (in_c == 64), done, busy, 8'(out_c), 8'(in_c)};
  endfunction

  task automatic wb_xfer(input bit we, input logic [1:0] reg_i, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output bit err);
    bit got = 0;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = {28'd0, reg_i, 2'b00};
    wb_dat = dat; wb_sel = sel;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) begin
        got = 1;
        break;
      end
    end
    rdat = wb_rdat;
    err = wb_err;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 4'hF;
    if (!got) check("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_expect(input string tag, input logic [1:0] reg_i, input logic [31:0] dat,
                              input logic [3:0] sel, input bit exp_err);
    logic [31:0] r;
    bit e;
    wb_xfer(1, reg_i, dat, sel, r, e);
    check(tag, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic read_expect(input string tag, input logic [1:0] reg_i, input logic [3:0] sel,
                             input logic [31:0] exp_dat, input bit exp_err);
    logic [31:0] r;
    bit e;
    wb_xfer(0, reg_i, 32'd0, sel, r, e);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_dat"}, r, exp_err ? 32'd0 : exp_dat);
  endtask

  task automatic push_word(input logic [31:0] d);
    exp_in.push_back({(pos % FL) == FL - 1, d});
    pos++;
    write_expect("din_push", 2'd2, d, 4'hF, 0);
  endtask

  task automatic clear_model();
    exp_in.delete();
    res_q.delete();
    exp_out.delete();
    pos = 0;
  endtask

  task automatic run_stream(input int n, input bit toggle);
    int seen = 0;
    logic [32:0] e;
    for (int c = 0; c < 400 && seen < n; c++) begin
      @(posedge clk); #1;
      core_rdy = toggle ? ~core_rdy : 1'b1;
      @(negedge clk);
      if (core_vld && core_rdy) begin
        if (exp_in.size() == 0) begin
          check("beat_extra", 32'd1, 32'd0);
        end else begin
          e = exp_in.pop_front();
          check("beat_dat", core_dat, e[31:0]);
          check("beat_last", {31'd0, core_last}, {31'd0, e[32]});
          res_q.push_back(core_dat ^ 32'h5A5A_0000);
        end
        seen++;
      end
    end
    @(posedge clk); #1;
    core_rdy = 1'b0;
    if (seen < n) check("stream_timeout", seen, n);
  endtask

  task automatic send_results(input int n);
    int sent = 0;
    int guard = 0;
    @(posedge clk); #1;
    while (sent < n && guard < 1000 && res_q.size() > 0) begin
      res_vld = 1; res_dat = res_q[0];
      @(negedge clk);
      guard++;
      if (res_rdy) begin
        exp_out.push_back(res_q.pop_front());
        sent++;
      end
      @(posedge clk); #1;
    end
    res_vld = 0;
    if (sent < n) check("res_timeout", sent, n);
  endtask

  initial begin
    // Reset values while held
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {27'd0, wb_ack, wb_err, core_vld, core_last, res_rdy}, 32'd0);
    check("rst_dat", wb_rdat | core_dat, 32'd0);
    @(negedge clk);
    rst_n = 1;
    read_expect("status_reset", 2'd1, 4'hF, 32'h0008_0000, 0);

    // Illegal accesses
    read_expect("ctrl_read", 2'd0, 4'hF, 32'd0, 1);
    write_expect("status_write", 2'd1, 32'hFFFF_FFFF, 4'hF, 1);
    read_expect("din_read", 2'd2, 4'hF, 32'd0, 1);
    read_expect("dout_empty", 2'd3, 4'hF, 32'd0, 1);
    write_expect("start_empty", 2'd0, 32'd1, 4'hF, 1);

    // Full frame with continuous ready
    for (int i = 0; i < FL; i++) push_word(32'(i));
    write_expect("din_sel3", 2'd2, 32'hDEAD_BEEF, 4'h3, 1);
    write_expect("din_full", 2'd2, 32'hDEAD_BEEF, 4'hF, 1);
    read_expect("status_full", 2'd1, 4'hF, st(64, 0, 0, 0), 0);
    write_expect("start1", 2'd0, 32'd1, 4'hF, 0);
    read_expect("status_busy", 2'd1, 4'hF, st(64, 0, 1, 0), 0);
    run_stream(FL, 0);
    read_expect("status_wait", 2'd1, 4'hF, st(0, 0, 1, 0), 0);
`ifdef IDFT_FEEDER_IRQ_EN
    check("irq_wait", {31'd0, irq}, 32'd0);
`endif
    send_results(FL);
    read_expect("status_done", 2'd1, 4'hF, st(0, 64, 0, 1), 0);
`ifdef IDFT_FEEDER_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
    write_expect("irq_clr", 2'd0, 32'd4, 4'hF, 0);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    write_expect("irq_clr_ign", 2'd0, 32'd4, 4'hF, 0);
`endif
    read_expect("dout_sel3", 2'd3, 4'h3, 32'd0, 1);
    for (int i = 0; i < FL; i++) read_expect("dout", 2'd3, 4'hF, exp_out.pop_front(), 0);
    read_expect("dout_drained", 2'd3, 4'hF, 32'd0, 1);
    read_expect("status_drained", 2'd1, 4'hF, st(0, 0, 0, 1), 0);

    // Backpressure frame, then flush while waiting on results
    for (int i = 0; i < FL; i++) push_word($urandom);
    write_expect("start2", 2'd0, 32'd1, 4'hF, 0);
    run_stream(FL, 1);
    send_results(10);
    read_expect("status_10res", 2'd1, 4'hF, st(0, 10, 1, 0), 0);
    write_expect("flush_wait", 2'd0, 32'd2, 4'hF, 0);
    check("vld_after_flush", {31'd0, core_vld}, 32'd0);
    read_expect("status_flushed", 2'd1, 4'hF, st(0, 0, 0, 0), 0);
    clear_model();

    // Start refused with too few samples leaves them in place
    for (int i = 0; i < 3; i++) push_word(32'h100 + 32'(i));
    write_expect("start_short", 2'd0, 32'd1, 4'hF, 1);
    read_expect("status_short", 2'd1, 4'hF, st(3, 0, 0, 0), 0);
    write_expect("flush_short", 2'd0, 32'd2, 4'hF, 0);
    clear_model();

    // Flush while streaming drops valid immediately
    for (int i = 0; i < FL; i++) push_word(32'h200 + 32'(i));
    write_expect("start3", 2'd0, 32'd1, 4'hF, 0);
    check("vld_streaming", {31'd0, core_vld}, 32'd1);
    write_expect("flush_stream", 2'd0, 32'd2, 4'hF, 0);
    check("vld_flush_stream", {31'd0, core_vld}, 32'd0);
    read_expect("status_flush2", 2'd1, 4'hF, st(0, 0, 0, 0), 0);
    clear_model();

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < FL; i++) push_word(32'h300 + 32'(i));
    write_expect("start4", 2'd0, 32'd1, 4'hF, 0);
    check("vld_pre_reset", {31'd0, core_vld}, 32'd1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("areset_outs", {27'd0, wb_ack, wb_err, core_vld, core_last, res_rdy}, 32'd0);
    check("areset_dat", wb_rdat | core_dat, 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    read_expect("status_after_rst", 2'd1, 4'hF, 32'h0008_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
